// File: rtl/idex_operand_stage.sv
// idex_operand_stage: DLX ID/EX register with operand forwarding, hazard stall and stall counter.
// Define IDEX_FORWARDING_EN to enable forwarding with the load-use-only hazard rule.
module idex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic              id_uses_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic              id_is_load,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              id_stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_is_load,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs2_fwd,
  output logic [31:0]       stall_count
);
  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              load;
    logic              use_imm;
    logic [OP_W-1:0]   op;
    logic [RA_W-1:0]   rd;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] imm;
  } ex_t;
  ex_t ex_q, ex_d;
  logic [31:0] stall_q, stall_d;
  logic hazard, rs1_ex, rs2_ex;
  logic [DATA_W-1:0] rs1_v, rs2_v;
  assign rs1_ex = id_rs1 == ex_q.rd;
  assign rs2_ex = id_uses_rs2 && id_rs2 == ex_q.rd;
`ifdef IDEX_FORWARDING_EN
  logic a_mem, a_wb, b_mem, b_wb;
  assign hazard = id_valid && ex_q.valid && ex_q.load && ex_q.rw && ex_q.rd != '0 && (rs1_ex || rs2_ex);
  // r0 is hardwired zero, so a match on it never forwards
  assign a_mem = exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs1;
  assign a_wb  = memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs1;
  assign b_mem = exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_q.rs2;
  assign b_wb  = memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_q.rs2;
  assign rs1_v = a_mem ? exmem_result : a_wb ? memwb_result : ex_q.d1;
  assign rs2_v = b_mem ? exmem_result : b_wb ? memwb_result : ex_q.d2;
`else
  logic rs1_mem, rs2_mem, unused_fwd;
  // write-first register file covers MEM/WB, so only EX and EX/MEM producers stall
  assign rs1_mem = id_rs1 == exmem_rd;
  assign rs2_mem = id_uses_rs2 && id_rs2 == exmem_rd;
  assign hazard = id_valid && ((ex_q.valid && ex_q.rw && ex_q.rd != '0 && (rs1_ex || rs2_ex)) ||
                               (exmem_reg_write && exmem_rd != '0 && (rs1_mem || rs2_mem)));
  assign rs1_v = ex_q.d1;
  assign rs2_v = ex_q.d2;
  assign unused_fwd = ^{exmem_result, memwb_rd, memwb_reg_write, memwb_result, ex_q.rs1, ex_q.rs2};
`endif
  assign id_stall = hazard && !flush && !reset;
  assign stall_d  = stall_q + {31'b0, id_stall && stall_q != '1};
  always_comb begin
    ex_d = (flush || hazard) ? '0 : ex_t'{valid: id_valid, rw: id_reg_write, load: id_is_load,
      use_imm: id_use_imm, op: id_op, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
      d1: id_rs1_data, d2: id_rs2_data, imm: id_imm};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      stall_q <= '0;
    end else begin
      ex_q    <= ex_d;
      stall_q <= stall_d;
    end
  end
  assign alu_a        = rs1_v;
  assign alu_b        = ex_q.use_imm ? ex_q.imm : rs2_v;
  assign ex_rs2_fwd   = rs2_v;
  assign alu_op       = ex_q.op;
  assign ex_rd        = ex_q.rd;
  assign ex_reg_write = ex_q.rw;
  assign ex_is_load   = ex_q.load;
  assign ex_valid     = ex_q.valid;
  assign stall_count  = stall_q;
endmodule

// File: tb/tb_idex_operand_stage.sv
// tb_idex_operand_stage: directed checks of capture, bubbles, hazards, forwarding and async reset.
module tb_idex_operand_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        id_valid, id_uses_rs2, id_use_imm, id_is_load, id_reg_write, flush;
  logic [4:0]  id_op, id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
  logic        exmem_reg_write, memwb_reg_write;
  logic        id_stall, ex_reg_write, ex_is_load, ex_valid;
  logic [31:0] alu_a, alu_b, ex_rs2_fwd, stall_count;
  logic [4:0]  alu_op, ex_rd;
  int errors = 0, checks = 0;

  idex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_is_load(id_is_load), .id_reg_write(id_reg_write),
    .flush(flush), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .id_stall(id_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_valid(ex_valid),
    .ex_rs2_fwd(ex_rs2_fwd), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input logic v, input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                    input logic u2, input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                    input logic rw, input logic ld);
    id_valid = v; id_op = op; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_reg_write = rw; id_is_load = ld;
    id_imm = '0; id_use_imm = 1'b0;
    #1;
  endtask

  initial begin
    flush = 0; exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_valid", {31'b0, ex_valid}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_op", {27'b0, alu_op}, 0);
    chk("rst_cnt", stall_count, 0);
    chk("rst_stall", {31'b0, id_stall}, 0);
    @(negedge clk);
    reset = 0;
    // plain add, no hazards
    id(1, 5'b00010, 1, 2, 1, 3, 5, 4, 1, 0);
    chk("add_stall", {31'b0, id_stall}, 0);
    tick();
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 4);
    chk("add_op", {27'b0, alu_op}, 2);
    chk("add_valid", {31'b0, ex_valid}, 1);
    chk("add_rd", {27'b0, ex_rd}, 3);
    chk("add_rs2fwd", ex_rs2_fwd, 4);
    // r0 never forwarded, immediate selected for B
    id(1, 5'b00001, 0, 0, 0, 4, 0, 32'h22, 0, 0);
    id_imm = 32'hFFFF_FFF9; id_use_imm = 1;
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hDEAD;
    #1;
    chk("imm_stall", {31'b0, id_stall}, 0);
    tick();
    chk("r0_a", alu_a, 0);
    chk("imm_b", alu_b, 32'hFFFF_FFF9);
    chk("imm_rs2fwd", ex_rs2_fwd, 32'h22);
    exmem_reg_write = 0;
`ifdef IDEX_FORWARDING_EN
    id(1, 5'b00001, 3, 2, 1, 8, 32'h55, 4, 1, 0);
    tick();
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h3FF;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'h111;
    #1;
    chk("fwd_exmem", alu_a, 32'h3FF);
    exmem_reg_write = 0; #1;
    chk("fwd_memwb", alu_a, 32'h111);
    memwb_reg_write = 0; #1;
    chk("fwd_none", alu_a, 32'h55);
    memwb_rd = 2; memwb_reg_write = 1; memwb_result = 32'h77; #1;
    chk("fwd_b", alu_b, 32'h77);
    chk("fwd_rs2", ex_rs2_fwd, 32'h77);
    memwb_reg_write = 0;
    // load-use stall
    id(1, 5'b00001, 1, 0, 0, 7, 0, 0, 1, 1);
    tick();
    id(1, 5'b00010, 7, 0, 0, 9, 32'h70, 0, 1, 0);
    chk("lu_stall", {31'b0, id_stall}, 1);
    tick();
    chk("lu_cnt", stall_count, 1);
    chk("lu_bub_valid", {31'b0, ex_valid}, 0);
    chk("lu_bub_op", {27'b0, alu_op}, 0);
    chk("lu_once", {31'b0, id_stall}, 0);
    tick();
    chk("lu_issue_valid", {31'b0, ex_valid}, 1);
    chk("lu_issue_op", {27'b0, alu_op}, 2);
    chk("lu_issue_a", alu_a, 32'h70);
    // flush beats load-use
    id(1, 5'b00001, 1, 0, 0, 7, 0, 0, 1, 1);
    tick();
    id(1, 5'b00010, 1, 7, 0, 9, 0, 0, 1, 0);
    chk("rs2_unused", {31'b0, id_stall}, 0);
    id_uses_rs2 = 1; #1;
    chk("rs2_used", {31'b0, id_stall}, 1);
    flush = 1; #1;
    chk("flush_stall", {31'b0, id_stall}, 0);
    tick();
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_cnt", stall_count, 1);
    flush = 0;
`else
    // EX/MEM producer: stall repeats until it clears
    id(1, 5'b00011, 9, 0, 0, 10, 32'h99, 0, 1, 0);
    exmem_rd = 9; exmem_reg_write = 1; #1;
    chk("nf_stall1", {31'b0, id_stall}, 1);
    tick();
    chk("nf_cnt1", stall_count, 1);
    chk("nf_bub_valid", {31'b0, ex_valid}, 0);
    chk("nf_bub_op", {27'b0, alu_op}, 0);
    chk("nf_bub_a", alu_a, 0);
    chk("nf_stall2", {31'b0, id_stall}, 1);
    tick();
    chk("nf_cnt2", stall_count, 2);
    exmem_reg_write = 0; #1;
    chk("nf_clear", {31'b0, id_stall}, 0);
    tick();
    chk("nf_issue_valid", {31'b0, ex_valid}, 1);
    chk("nf_issue_a", alu_a, 32'h99);
    chk("nf_issue_op", {27'b0, alu_op}, 3);
    chk("nf_cnt_hold", stall_count, 2);
    // EX producer on rs2, then flush beats hazard
    id(1, 5'b00010, 1, 10, 0, 11, 0, 0, 1, 0);
    chk("rs2_unused", {31'b0, id_stall}, 0);
    id_uses_rs2 = 1; #1;
    chk("rs2_used", {31'b0, id_stall}, 1);
    flush = 1; #1;
    chk("flush_stall", {31'b0, id_stall}, 0);
    tick();
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_rw", {31'b0, ex_reg_write}, 0);
    chk("flush_cnt", stall_count, 2);
    flush = 0; #1;
    chk("after_flush", {31'b0, id_stall}, 0);
`endif
    // invalid slot keeps supplied controls
    id(0, 5'b00111, 0, 0, 0, 5, 0, 0, 1, 1);
    tick();
    chk("inv_valid", {31'b0, ex_valid}, 0);
    chk("inv_rw", {31'b0, ex_reg_write}, 1);
    chk("inv_load", {31'b0, ex_is_load}, 1);
    chk("inv_op", {27'b0, alu_op}, 7);
    chk("inv_rd", {27'b0, ex_rd}, 5);
    // asynchronous reset in the middle of a stall
`ifdef IDEX_FORWARDING_EN
    id(1, 5'b00001, 1, 0, 0, 7, 0, 0, 1, 1);
    tick();
    id(1, 5'b00010, 7, 0, 0, 9, 0, 0, 1, 0);
    chk("pre_rst_stall", {31'b0, id_stall}, 1);
    chk("pre_rst_valid", {31'b0, ex_valid}, 1);
`else
    id(1, 5'b00010, 9, 0, 0, 12, 0, 0, 1, 0);
    exmem_rd = 9; exmem_reg_write = 1; #1;
    tick();
    chk("pre_rst_cnt", stall_count, 3);
    chk("pre_rst_stall", {31'b0, id_stall}, 1);
`endif
    reset = 1; #1;
    chk("arst_valid", {31'b0, ex_valid}, 0);
    chk("arst_stall", {31'b0, id_stall}, 0);
    chk("arst_cnt", stall_count, 0);
    chk("arst_op", {27'b0, alu_op}, 0);
    @(negedge clk);
    reset = 0; exmem_reg_write = 0;
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("post_cnt", stall_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
